mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage of the pipelined RiSC-16 core, between the EX/MEM boundary and writeback.
- Accepts one ALU-pass, load or store op per cycle and drives the synchronous data memory directly.
- Absorbs the memory's 1-cycle read latency and holds load data while writeback stalls.
- Presents results to writeback via a valid/ready handshake.

Parameters:
- p_WORD_LEN, 16, data word width in bits.
- p_ADDR_LEN, 10, data memory address lines; must be at most p_WORD_LEN.
- p_CHECK_RANGE, 1, when 1 a nonzero value in address bits above p_ADDR_LEN is an address fault.

Ports:
- i_clk  in  1  clock, all state updates on posedge.
- i_rst  in  1  asynchronous active-high reset.
- i_ex_valid  in  1  upstream op valid.
- o_ex_ready  out  1  stage can accept an op this cycle.
- i_ex_op  in  2  00 ALU-pass, 01 load, 10 store, 11 nop (accepted, no writeback).
- i_ex_alu  in  p_WORD_LEN  ALU result, or effective word address for load/store.
- i_ex_st_data  in  p_WORD_LEN  store data.
- i_ex_rd  in  3  destination register.
- o_mem_addr  out  p_ADDR_LEN  memory address, combinational = i_ex_alu[p_ADDR_LEN-1:0].
- o_mem_wr_en  out  1  memory write strobe.
- o_mem_wr_data  out  p_WORD_LEN  = i_ex_st_data.
- i_mem_rd_data  in  p_WORD_LEN  memory read data, valid 1 cycle after the address.
- o_wb_valid  out  1  result valid.
- i_wb_ready  in  1  writeback accepts.
- o_wb_data  out  p_WORD_LEN  result value.
- o_wb_rd  out  3  destination register.
- o_wb_we  out  1  register write enable.
- o_addr_fault  out  1  sticky address-fault flag.

Behaviour:
- Reset (async, i_rst=1): r_valid, r_hold_valid, o_wb_valid, o_wb_data, o_wb_rd, o_wb_we and o_addr_fault all 0. o_ex_ready is forced 0 while i_rst is high.
- Ready: o_ex_ready = !i_rst && (!r_valid || i_wb_ready). accept = i_ex_valid && o_ex_ready.
- Fault: fault = p_CHECK_RANGE && (i_ex_alu[p_WORD_LEN-1:p_ADDR_LEN] != 0) && op is load or store.
- Write strobe: o_mem_wr_en = accept && op==store && !fault. It is never asserted without accept.
- On accept, the output register loads: r_valid=1, op, rd, alu, fault_bit. o_addr_fault sets on accepting a faulting op and clears only on reset.
- If not accepted and writeback takes the output (i_wb_ready && r_valid), r_valid clears.
- Latency: 1 cycle from accept to o_wb_valid for every op.
- o_wb_valid = r_valid.
- o_wb_we = r_valid && op in {ALU, load} && rd != 0 && !fault_bit.
- Data select for o_wb_data:
  - ALU op: alu.
  - Load with fault_bit: 0.
  - Load with r_hold_valid: r_hold.
  - Load otherwise: i_mem_rd_data.
  - Store or nop: 0.
- Hold register: at a posedge where r_valid && load && !r_hold_valid && !i_wb_ready, capture r_hold <= i_mem_rd_data and set r_hold_valid=1. This is required because the memory re-reads on every cycle's address.
- r_hold_valid clears when the held op hands off (r_valid && i_wb_ready). A new accept in the same cycle starts with r_hold_valid=0.
- Back-to-back: store to A then load from A on the next cycle returns the new data (the write completes before the read edge). This needs no forwarding in this block.
- Reset mid-operation drops any in-flight or held result. A store already strobed stays written.
- o_mem_addr toggles freely during stalls; a stall must not change o_wb_data for a held load.

Test Plan:
- Reset then ALU op alu=0x1234 rd=3 with i_wb_ready=1 -> next cycle o_wb_valid=1, o_wb_data=0x1234, o_wb_we=1, o_wb_rd=3. Repeat with rd=0 -> o_wb_we=0.
- Store 0xBEEF to address 0x005, then load from 0x005 on the next cycle -> o_mem_wr_en high for exactly 1 cycle, and the load result is 0xBEEF one cycle after its accept.
- Load from address 0x00A holding 0x7777, with i_wb_ready=0 for 3 cycles while the upstream drives different addresses -> o_ex_ready=0 and o_wb_data stays 0x7777 throughout; hands off on the first ready cycle.
- Store to address 0x0400 with p_ADDR_LEN=10 -> o_mem_wr_en=0 and o_addr_fault=1 (stays 1). A load from 0x8001 gives o_wb_data=0 and o_wb_we=0.
- Stream of 4 accepted ops with i_wb_ready held at 1 -> 4 consecutive o_wb_valid cycles, no bubbles, order preserved.
- Assert i_rst during a stalled load -> o_wb_valid drops to 0 immediately. After release, the next op flows normally with r_hold_valid=0.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: RiSC-16 MEM pipeline stage driving sync data memory with load hold and writeback handshake
module mem_stage #(
  parameter int p_WORD_LEN    = 16,
  parameter int p_ADDR_LEN    = 10,
  parameter bit p_CHECK_RANGE = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_valid,
  output logic                  o_ex_ready,
  input  logic [1:0]            i_ex_op,
  input  logic [p_WORD_LEN-1:0] i_ex_alu,
  input  logic [p_WORD_LEN-1:0] i_ex_st_data,
  input  logic [2:0]            i_ex_rd,
  output logic [p_ADDR_LEN-1:0] o_mem_addr,
  output logic                  o_mem_wr_en,
  output logic [p_WORD_LEN-1:0] o_mem_wr_data,
  input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
  output logic                  o_wb_valid,
  input  logic                  i_wb_ready,
  output logic [p_WORD_LEN-1:0] o_wb_data,
  output logic [2:0]            o_wb_rd,
  output logic                  o_wb_we,
  output logic                  o_addr_fault
);
  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;
  logic                  r_valid;
  logic                  r_hold_valid;
  logic                  r_fault;
  logic                  r_addr_fault;
  logic [1:0]            r_op;
  logic [2:0]            r_rd;
  logic [p_WORD_LEN-1:0] r_alu;
  logic [p_WORD_LEN-1:0] r_hold;
  logic                  accept;
  logic                  fault;
  // upstream handshake, address range check and direct memory drive
  always_comb begin
    fault         = p_CHECK_RANGE && ((i_ex_alu >> p_ADDR_LEN) != '0) && (i_ex_op == OP_LD || i_ex_op == OP_ST);
    o_ex_ready    = !i_rst && (!r_valid || i_wb_ready);
    accept        = i_ex_valid && o_ex_ready;
    o_mem_addr    = i_ex_alu[p_ADDR_LEN-1:0];
    o_mem_wr_en   = accept && i_ex_op == OP_ST && !fault;
    o_mem_wr_data = i_ex_st_data;
  end
  // writeback presentation; a held load beats the live memory output, which follows the current address
  always_comb begin
    o_wb_valid   = r_valid;
    o_wb_rd      = r_rd;
    o_wb_we      = r_valid && (r_op == OP_ALU || r_op == OP_LD) && r_rd != 3'd0 && !r_fault;
    o_wb_data    = r_op == OP_ALU ? r_alu :
                   r_op != OP_LD  ? '0 :
                   r_fault        ? '0 :
                   r_hold_valid   ? r_hold : i_mem_rd_data;
    o_addr_fault = r_addr_fault;
  end
  // output register, load-data capture on the first stalled cycle, sticky fault flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid      <= 1'b0;
      r_hold_valid <= 1'b0;
      r_fault      <= 1'b0;
      r_addr_fault <= 1'b0;
      r_op         <= OP_NOP;
      r_rd         <= 3'd0;
      r_alu        <= '0;
      r_hold       <= '0;
    end else begin
      if (accept) begin
        r_valid      <= 1'b1;
        r_op         <= i_ex_op;
        r_rd         <= i_ex_rd;
        r_alu        <= i_ex_alu;
        r_fault      <= fault;
        r_hold_valid <= 1'b0;
      end else if (r_valid && i_wb_ready) begin
        r_valid      <= 1'b0;
        r_hold_valid <= 1'b0;
      end else if (r_valid && r_op == OP_LD && !r_hold_valid) begin
        r_hold       <= i_mem_rd_data;
        r_hold_valid <= 1'b1;
      end
      if (accept && fault) r_addr_fault <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed checks of mem_stage against a behavioural sync memory
module tb_mem_stage;
  localparam logic [1:0] ALU = 2'b00;
  localparam logic [1:0] LD  = 2'b01;
  localparam logic [1:0] ST  = 2'b10;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_op = 2'b11;
  logic [15:0] ex_alu = '0;
  logic [15:0] ex_st_data = '0;
  logic [2:0]  ex_rd = '0;
  logic [9:0]  mem_addr;
  logic        mem_wr_en;
  logic [15:0] mem_wr_data;
  logic [15:0] mem_rd_data = '0;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_we;
  logic        addr_fault;
  int          checks = 0;
  int          errors = 0;
  bit [15:0]   mem  [0:1023];
  bit          mark [0:1023];

  mem_stage dut (
    .i_clk(clk), .i_rst(rst), .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_op(ex_op), .i_ex_alu(ex_alu), .i_ex_st_data(ex_st_data), .i_ex_rd(ex_rd),
    .o_mem_addr(mem_addr), .o_mem_wr_en(mem_wr_en), .o_mem_wr_data(mem_wr_data),
    .i_mem_rd_data(mem_rd_data), .o_wb_valid(wb_valid), .i_wb_ready(wb_ready),
    .o_wb_data(wb_data), .o_wb_rd(wb_rd), .o_wb_we(wb_we), .o_addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  // unwritten words read back as 0x0100 + address so every location is distinct
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr]  <= mem_wr_data;
      mark[mem_addr] <= 1'b1;
    end
    mem_rd_data <= mark[mem_addr] ? mem[mem_addr] : 16'h0100 + {6'd0, mem_addr};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] rd);
    ex_valid   = v;
    ex_op      = op;
    ex_alu     = alu;
    ex_st_data = sd;
    ex_rd      = rd;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", wb_valid); end
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ex_ready); end
    checks++; if (wb_data !== 16'h0 || wb_we !== 1'b0) begin errors++; $display("FAIL reset_data got=%h/%b exp=0000/0", wb_data, wb_we); end
    checks++; if (addr_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", addr_fault); end
    rst = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", ex_ready); end
  endtask

  task automatic test_alu;
    wb_ready = 1'b1;
    drive(1, ALU, 16'h1234, 16'h0, 3'd3);
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h1234 || wb_we !== 1'b1 || wb_rd !== 3'd3) begin
      errors++; $display("FAIL alu_rd3 got=%b/%h/%b/%0d exp=1/1234/1/3", wb_valid, wb_data, wb_we, wb_rd); end
    drive(1, ALU, 16'h4321, 16'h0, 3'd0);
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h4321 || wb_we !== 1'b0) begin
      errors++; $display("FAIL alu_rd0 got=%b/%h/%b exp=1/4321/0", wb_valid, wb_data, wb_we); end
    drive(0, ALU, 16'h0, 16'h0, 3'd0);
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_store_load;
    drive(1, ST, 16'h0005, 16'hBEEF, 3'd1);
    #1;
    checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 10'h005) begin errors++; $display("FAIL st_strobe got=%b@%h exp=1@005", mem_wr_en, mem_addr); end
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0 || wb_data !== 16'h0) begin errors++; $display("FAIL st_result got=%b/%b/%h exp=1/0/0000", wb_valid, wb_we, wb_data); end
    drive(1, LD, 16'h0005, 16'h0, 3'd2);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL st_one_cycle got=%b exp=0", mem_wr_en); end
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'hBEEF || wb_we !== 1'b1 || wb_rd !== 3'd2) begin
      errors++; $display("FAIL ld_after_st got=%b/%h/%b/%0d exp=1/beef/1/2", wb_valid, wb_data, wb_we, wb_rd); end
    drive(0, ALU, 16'h0, 16'h0, 3'd0);
    tick;
  endtask

  task automatic test_stall;
    drive(1, ST, 16'h000A, 16'h7777, 3'd0);
    tick;
    drive(1, LD, 16'h000A, 16'h0, 3'd4);
    tick;
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, ST, 16'h0020 + 16'(i), 16'hDEAD, 3'd0);
      #1;
      checks++; if (ex_ready !== 1'b0 || mem_wr_en !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d got=%b/%b exp=0/0", i, ex_ready, mem_wr_en); end
      checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h7777 || wb_rd !== 3'd4) begin
        errors++; $display("FAIL stall_hold_%0d got=%b/%h/%0d exp=1/7777/4", i, wb_valid, wb_data, wb_rd); end
      tick;
    end
    drive(0, ALU, 16'h0033, 16'h0, 3'd0);
    wb_ready = 1'b1;
    #1;
    checks++; if (ex_ready !== 1'b1 || wb_data !== 16'h7777 || wb_we !== 1'b1) begin
      errors++; $display("FAIL stall_handoff got=%b/%h/%b exp=1/7777/1", ex_ready, wb_data, wb_we); end
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_fault;
    drive(1, ST, 16'h0400, 16'h1357, 3'd0);
    #1;
    checks++; if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL fault_strobe got=%b exp=0", mem_wr_en); end
    tick;
    checks++; if (addr_fault !== 1'b1 || wb_valid !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL fault_store got=%b/%b/%b exp=1/1/0", addr_fault, wb_valid, wb_we); end
    drive(1, LD, 16'h8001, 16'h0, 3'd5);
    tick;
    checks++; if (wb_data !== 16'h0 || wb_we !== 1'b0 || wb_valid !== 1'b1) begin
      errors++; $display("FAIL fault_load got=%h/%b/%b exp=0000/0/1", wb_data, wb_we, wb_valid); end
    drive(1, ALU, 16'h8001, 16'h0, 3'd5);
    tick;
    checks++; if (addr_fault !== 1'b1 || wb_we !== 1'b1 || wb_data !== 16'h8001) begin
      errors++; $display("FAIL fault_sticky got=%b/%b/%h exp=1/1/8001", addr_fault, wb_we, wb_data); end
    drive(0, ALU, 16'h0, 16'h0, 3'd0);
    tick;
  endtask

  task automatic test_back_to_back;
    logic [1:0]  ops [4] = '{ALU, LD, ALU, LD};
    logic [15:0] alus[4] = '{16'hA001, 16'h0030, 16'hA003, 16'h0031};
    logic [15:0] exps[4] = '{16'hA001, 16'h0130, 16'hA003, 16'h0131};
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1, ops[i], alus[i], 16'h0, 3'(i + 1));
      tick;
      checks++; if (wb_valid !== 1'b1 || wb_data !== exps[i] || wb_rd !== 3'(i + 1)) begin
        errors++; $display("FAIL b2b_%0d got=%b/%h/%0d exp=1/%h/%0d", i, wb_valid, wb_data, wb_rd, exps[i], i + 1); end
    end
    drive(0, ALU, 16'h0, 16'h0, 3'd0);
    tick;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%b exp=0", wb_valid); end
  endtask

  task automatic test_reset_mid;
    drive(1, LD, 16'h0040, 16'h0, 3'd6);
    tick;
    wb_ready = 1'b0;
    drive(0, ALU, 16'h0050, 16'h0, 3'd0);
    tick;
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0140) begin errors++; $display("FAIL rmid_held got=%b/%h exp=1/0140", wb_valid, wb_data); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (wb_valid !== 1'b0 || ex_ready !== 1'b0 || addr_fault !== 1'b0) begin
      errors++; $display("FAIL rmid_drop got=%b/%b/%b exp=0/0/0", wb_valid, ex_ready, addr_fault); end
    tick;
    rst = 1'b0;
    wb_ready = 1'b1;
    drive(1, ALU, 16'h0F0F, 16'h0, 3'd7);
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0F0F || wb_we !== 1'b1 || wb_rd !== 3'd7) begin
      errors++; $display("FAIL rmid_alu got=%b/%h/%b/%0d exp=1/0f0f/1/7", wb_valid, wb_data, wb_we, wb_rd); end
    drive(1, LD, 16'h0041, 16'h0, 3'd6);
    tick;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h0141) begin errors++; $display("FAIL rmid_load got=%b/%h exp=1/0141", wb_valid, wb_data); end
    drive(0, ALU, 16'h0, 16'h0, 3'd0);
    tick;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_store_load;
    test_stall;
    test_fault;
    test_back_to_back;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
